// File: rtl/adc_scan_sequencer.sv
// Rate-tick driven multi-channel ADC scan over one SPI master; results are channel-tagged into a FWFT FIFO.
// Optional SPI watchdog in WAIT is enabled by defining SPI_TIMEOUT_EN.
module adc_scan_sequencer #(
    parameter int         NUM_CH      = 4,
    parameter int         DIV_W       = 16,
    parameter int         FIFO_ABITS  = 6,
    parameter logic [6:0] CMD_HI      = 7'b0001100,
    parameter logic [6:0] CMD_LO      = 7'b1000000,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [DIV_W-1:0]  i_rate_div,
    input  logic [NUM_CH-1:0] i_ch_mask,
    input  logic              i_stat_clr,
    output logic              o_spi_ena,
    output logic [15:0]       o_spi_cmd,
    input  logic              i_spi_fin,
    input  logic [15:0]       i_spi_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [15:0]       o_out_data,
    output logic [1:0]        o_out_ch,
    output logic              o_busy,
    output logic              o_overrun,
    output logic [7:0]        o_drop_cnt,
    output logic [7:0]        o_miss_cnt
);

    localparam int DEPTH = 1 << FIFO_ABITS;

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_START, S_WAIT, S_STORE} state_t;

    state_t                r_state;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [NUM_CH-1:0]     r_mask;
    logic [1:0]            r_ch;
    logic [15:0]           r_data;
    logic                  r_spi_ena;
    logic [15:0]           r_spi_cmd;
    logic                  r_overrun;
    logic [7:0]            r_drop_cnt;
    logic [7:0]            r_miss_cnt;
    logic [17:0]           r_mem [DEPTH];
    logic [FIFO_ABITS-1:0] r_wp;
    logic [FIFO_ABITS-1:0] r_rp;
    logic [FIFO_ABITS:0]   r_fcnt;

    logic                  w_tick;
    logic [1:0]            w_next_ch;
    logic [NUM_CH-1:0]     w_mask_rest;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;
    logic [17:0]           w_head;

    function automatic logic [1:0] f_lowest(input logic [NUM_CH-1:0] m);
        f_lowest = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = 2'(i);
        end
    endfunction

    // >= rather than == so a shrinking rate_div cannot strand the counter above it
    assign w_tick      = i_enable && (r_div_cnt >= i_rate_div);
    assign w_next_ch   = f_lowest(r_mask);
    assign w_mask_rest = r_mask & (r_mask - NUM_CH'(1));

    always_ff @(posedge i_clock) begin
        if (i_reset || !i_enable || w_tick) r_div_cnt <= '0;
        else                                r_div_cnt <= r_div_cnt + DIV_W'(1);
    end

`ifdef SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_ch      <= 2'd0;
            r_data    <= 16'h0;
            r_spi_ena <= 1'b0;
            r_spi_cmd <= 16'h0;
`ifdef SPI_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
        end else begin
            r_spi_ena <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick && (i_ch_mask != '0)) begin
                        r_mask  <= i_ch_mask;
                        r_state <= S_SEL;
                    end
                end
                S_SEL: begin
                    r_ch      <= w_next_ch;
                    r_mask    <= w_mask_rest;
                    r_spi_ena <= 1'b1;
                    r_spi_cmd <= {CMD_HI, w_next_ch, CMD_LO};
                    r_state   <= S_START;
                end
                S_START: begin
`ifdef SPI_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_spi_fin) begin
                        r_data  <= i_spi_data;
                        r_state <= S_STORE;
                    end
`ifdef SPI_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_data  <= 16'hFFFF;
                        r_state <= S_STORE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`endif
                end
                S_STORE: begin
                    // a falling enable lets the in-flight sample land, then stops the scan
                    if (i_enable && (r_mask != '0)) begin
                        r_ch      <= w_next_ch;
                        r_mask    <= w_mask_rest;
                        r_spi_ena <= 1'b1;
                        r_spi_cmd <= {CMD_HI, w_next_ch, CMD_LO};
                        r_state   <= S_START;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_out_valid = (r_fcnt != '0);
    assign w_push      = (r_state == S_STORE);
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_full      = (r_fcnt == (FIFO_ABITS + 1)'(DEPTH));
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_head      = r_mem[r_rp];

    always_ff @(posedge i_clock) begin
        if (w_wr) r_mem[r_wp] <= {r_ch, r_data};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_wr)  r_wp <= r_wp + FIFO_ABITS'(1);
            if (w_pop) r_rp <= r_rp + FIFO_ABITS'(1);
            case ({w_wr, w_pop})
                2'b10:   r_fcnt <= r_fcnt + (FIFO_ABITS + 1)'(1);
                2'b01:   r_fcnt <= r_fcnt - (FIFO_ABITS + 1)'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // clear takes priority over a coincident drop or miss
    always_ff @(posedge i_clock) begin
        if (i_reset || i_stat_clr) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= 8'd0;
            r_miss_cnt <= 8'd0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_tick && (r_state != S_IDLE) && (r_miss_cnt != 8'hFF))
                r_miss_cnt <= r_miss_cnt + 8'd1;
        end
    end

    assign o_spi_ena  = r_spi_ena;
    assign o_spi_cmd  = r_spi_cmd;
    assign o_out_data = o_out_valid ? w_head[15:0]  : 16'h0;
    assign o_out_ch   = o_out_valid ? w_head[17:16] : 2'd0;
    assign o_busy     = (r_state != S_IDLE);
    assign o_overrun  = r_overrun;
    assign o_drop_cnt = r_drop_cnt;
    assign o_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a scripted SPI slave and a 4-entry FIFO.
module tb_adc_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, stat_clr, spi_ena, spi_fin, out_valid, out_ready;
    logic        busy, overrun;
    logic [15:0] rate_div, spi_cmd, spi_data, out_data;
    logic [3:0]  ch_mask;
    logic [1:0]  out_ch;
    logic [7:0]  drop_cnt, miss_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          t0      = 0;
    int          fin_lat = 20;
    bit          resp_on = 1'b1;
    logic [15:0] cmd_q[$];
    int          ena_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_scan_sequencer #(.FIFO_ABITS(2)) dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_enable   (enable),
        .i_rate_div (rate_div),
        .i_ch_mask  (ch_mask),
        .i_stat_clr (stat_clr),
        .o_spi_ena  (spi_ena),
        .o_spi_cmd  (spi_cmd),
        .i_spi_fin  (spi_fin),
        .i_spi_data (spi_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_out_ch   (out_ch),
        .o_busy     (busy),
        .o_overrun  (overrun),
        .o_drop_cnt (drop_cnt),
        .o_miss_cnt (miss_cnt)
    );

    // SPI slave: answers each start pulse fin_lat cycles later with 16'hA5A0 | channel
    initial begin : spi_model
        spi_fin  = 1'b0;
        spi_data = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (spi_ena && resp_on) begin
                cmd_q.push_back(spi_cmd);
                ena_cyc.push_back(cyc);
                repeat (fin_lat) @(posedge clk);
                #1;
                spi_fin  = 1'b1;
                spi_data = 16'hA5A0 | {14'd0, spi_cmd[8:7]};
                @(posedge clk); #1;
                spi_fin  = 1'b0;
                spi_data = 16'h0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int k);
        while (cyc - t0 < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : main
        int n;
        reset = 1'b1; enable = 1'b0; stat_clr = 1'b0; out_ready = 1'b0;
        rate_div = 16'd0; ch_mask = 4'd0;
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_ena", spi_ena, 0);
        chk("rst_cmd", spi_cmd, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        reset = 1'b0;
        step(2);
        chk("idle_no_enable", busy, 0);

        // T1: mask 0101, period 10, SPI latency 20
        rate_div = 16'd9; ch_mask = 4'b0101; fin_lat = 20;
        t0 = cyc; enable = 1'b1;
        goto(10); chk("t1_sel_busy", busy, 1); chk("t1_sel_no_ena", spi_ena, 0);
        goto(11); chk("t1_ena_ch0", spi_ena, 1); chk("t1_cmd_ch0", spi_cmd, 16'h1840);
        goto(32); chk("t1_store_not_valid", out_valid, 0);
        goto(33);
        chk("t1_valid", out_valid, 1);
        chk("t1_head_ch", out_ch, 0);
        chk("t1_head_data", out_data, 16'hA5A0);
        chk("t1_ena_ch2", spi_ena, 1);
        chk("t1_cmd_ch2", spi_cmd, 16'h1940);
        goto(56); enable = 1'b0;
        chk("t1_idle", busy, 0);
        chk("t1_miss", miss_cnt, 4);
        chk("t1_ncmd", cmd_q.size(), 2);
        out_ready = 1'b1; step(1); out_ready = 1'b0;
        chk("t1_pop2_ch", out_ch, 2);
        chk("t1_pop2_data", out_data, 16'hA5A2);
        out_ready = 1'b1; step(1); out_ready = 1'b0;
        chk("t1_empty", out_valid, 0);

        // T2: misses per tick while busy, saturation, clear
        stat_clr = 1'b1; step(1); stat_clr = 1'b0;
        chk("t2_clr", miss_cnt, 0);
        out_ready = 1'b1; rate_div = 16'd30; ch_mask = 4'b1111; fin_lat = 20;
        t0 = cyc; enable = 1'b1;
        goto(61); chk("t2_miss_before", miss_cnt, 0);
        goto(62); chk("t2_miss_one", miss_cnt, 1);
        goto(100); chk("t2_miss_two", miss_cnt, 2);
        rate_div = 16'd0;
        step(400); chk("t2_miss_sat", miss_cnt, 255);
        stat_clr = 1'b1; step(1); stat_clr = 1'b0; enable = 1'b0;
        chk("t2_clr_wins", miss_cnt, 0);
        n = 0;
        while (busy && n < 300) begin step(1); n++; end
        chk("t2_idle_in_time", busy, 0);
        step(2);
        chk("t2_miss_after", miss_cnt, 0);
        chk("t2_drop", drop_cnt, 0);
        chk("t2_drained", out_valid, 0);

        // T3: 4-entry FIFO overflow, then push on full with a pop
        out_ready = 1'b0; rate_div = 16'd9; ch_mask = 4'b0001; fin_lat = 1;
        ena_cyc.delete();
        t0 = cyc; enable = 1'b1;
        goto(53); chk("t3_pre_drop", drop_cnt, 0); chk("t3_pre_overrun", overrun, 0);
        goto(54);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_overrun", overrun, 1);
        chk("t3_tick_period", ena_cyc[1] - ena_cyc[0], 10);
        goto(63); out_ready = 1'b1;
        goto(64); out_ready = 1'b0; enable = 1'b0;
        chk("t3_full_pop_drop", drop_cnt, 1);
        n = 0; out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (out_valid) n++;
            step(1);
        end
        out_ready = 1'b0;
        chk("t3_entries", n, 4);
        chk("t3_pop_empty", out_valid, 0);

        // T4: enable drops during ch1 wait of mask 0011
        rate_div = 16'd9; ch_mask = 4'b0011; fin_lat = 20;
        cmd_q.delete();
        t0 = cyc; enable = 1'b1;
        goto(40); enable = 1'b0; chk("t4_busy_wait", busy, 1);
        goto(54); chk("t4_busy_store", busy, 1);
        goto(55); chk("t4_idle", busy, 0);
        goto(75);
        chk("t4_ncmd", cmd_q.size(), 2);
        chk("t4_cmd_ch1", cmd_q[1], 16'h18C0);
        chk("t4_no_ena", spi_ena, 0);
        chk("t4_miss", miss_cnt, 3);
        chk("t4_head_ch0", out_ch, 0);
        out_ready = 1'b1; step(1); out_ready = 1'b0;
        chk("t4_head_ch1", out_ch, 1);
        chk("t4_head_data1", out_data, 16'hA5A1);

        // T5: reset during WAIT flushes everything
        rate_div = 16'd9; ch_mask = 4'b0001; fin_lat = 20;
        t0 = cyc; enable = 1'b1;
        goto(15); chk("t5_busy", busy, 1);
        reset = 1'b1; step(1);
        chk("t5_busy0", busy, 0);
        chk("t5_valid0", out_valid, 0);
        chk("t5_ena0", spi_ena, 0);
        chk("t5_miss0", miss_cnt, 0);
        chk("t5_drop0", drop_cnt, 0);
        chk("t5_overrun0", overrun, 0);
        chk("t5_cmd0", spi_cmd, 0);
        reset = 1'b0; enable = 1'b0;
        step(30);
        chk("t5_stray_fin", out_valid, 0);
        chk("t5_still_idle", busy, 0);

`ifdef SPI_TIMEOUT_EN
        // T6: SPI never answers, watchdog stores 16'hFFFF and moves on
        resp_on = 1'b0; rate_div = 16'd5; ch_mask = 4'b0011;
        t0 = cyc; enable = 1'b1;
        n = 0;
        while (!out_valid && n < 400) begin step(1); n++; end
        chk("t6_timeout_valid", out_valid, 1);
        chk("t6_timeout_data", out_data, 16'hFFFF);
        chk("t6_timeout_ch", out_ch, 0);
        chk("t6_next_cmd", spi_cmd, 16'h18C0);
        enable = 1'b0; reset = 1'b1; step(1); reset = 1'b0; resp_on = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
